// File: rtl/cal_date_pkg.sv
// Calendar date helpers shared by the month-info block and its interface.
//   - width localparams for weekday, day and month fields
//   - EPOCH_FIRST_DAY: weekday of 2000-01-01 (Saturday, Monday = 0)
//   - cal_state_t: weekday-calculation FSM states
//   - is_leap / days_in_month / add_mod7 / days_over_28 helper functions
package cal_date_pkg;

  localparam int WDAY_W  = 3;
  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;

  localparam logic [WDAY_W-1:0] EPOCH_FIRST_DAY = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    YEAR,
    MONTH,
    LOAD
  } cal_state_t;

  // Only years 2000..2099 are represented, so the century rule never applies.
  function automatic logic is_leap(input logic [1:0] year_lsb);
    return (year_lsb == 2'd0);
  endfunction

  function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                     input logic               leap);
    case (month)
      4'd1:                      return leap ? 5'd29 : 5'd28;
      4'd3, 4'd5, 4'd8, 4'd10:   return 5'd30;
      default:                   return 5'd31;
    endcase
  endfunction

  // Both operands are weekdays (0..6), so one conditional subtract suffices.
  function automatic logic [WDAY_W-1:0] add_mod7(input logic [WDAY_W-1:0] a,
                                                 input logic [WDAY_W-1:0] b);
    logic [WDAY_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 4'd7) s = s - 4'd7;
    return s[WDAY_W-1:0];
  endfunction

  // Weekday shift a month causes: its length minus four full weeks (0..3).
  function automatic logic [WDAY_W-1:0] days_over_28(input logic [DAY_W-1:0] days);
    logic [DAY_W-1:0] ex;
    ex = days - 5'd28;
    return ex[WDAY_W-1:0];
  endfunction

endpackage

// File: rtl/cal_month_info_if.sv
// Date-set handshake bundle for cal_month_info.
//   set_valid_i / set_ready_o : ready/valid handshake
//   set_year_i  : year offset from 2000
//   set_month_i : month, 0 = January
//   set_day_i   : day of month, 0-based
// master = requester (drives the date), slave = cal_month_info.
interface cal_month_info_if #(
  parameter int YEAR_W = 7
);
  logic              set_valid_i;
  logic              set_ready_o;
  logic [YEAR_W-1:0] set_year_i;
  logic [3:0]        set_month_i;
  logic [4:0]        set_day_i;

  modport master (
    output set_valid_i, set_year_i, set_month_i, set_day_i,
    input  set_ready_o
  );

  modport slave (
    input  set_valid_i, set_year_i, set_month_i, set_day_i,
    output set_ready_o
  );
endinterface

// File: rtl/cal_month_info.sv
// Calendar state keeper for the month-view renderer.
// Tracks the current date (2000..2099), advances it on day_tick_i, and on a
// user set recomputes the weekday of the 1st of the month with a sequential
// YEAR -> MONTH -> LOAD walk (one year or month per cycle, no dividers).
// Ports:
//   clk_i, rst_i (async, active-high)
//   day_tick_i        : one-cycle pulse, advance by one day
//   set_if (slave)    : ready/valid date set
//   year_o, month_o, day_in_month_o : current date (offset / 0-based)
//   month_first_day_o : weekday of the 1st of the current month, Monday = 0
//   month_days_cnt_o  : days in the current month
//   info_valid_o      : outputs consistent (low while calculating)
module cal_month_info #(
  parameter int               YEAR_W          = 7,
  parameter logic [2:0]       EPOCH_FIRST_DAY = cal_date_pkg::EPOCH_FIRST_DAY
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 day_tick_i,
  cal_month_info_if.slave      set_if,
  output logic [YEAR_W-1:0]    year_o,
  output logic [3:0]           month_o,
  output logic [4:0]           day_in_month_o,
  output logic [2:0]           month_first_day_o,
  output logic [4:0]           month_days_cnt_o,
  output logic                 info_valid_o
);
  import cal_date_pkg::*;

  localparam logic [YEAR_W-1:0]  YEAR_MAX  = YEAR_W'(99);
  localparam logic [MONTH_W-1:0] MONTH_MAX = 4'd11;

  cal_state_t          state_q;
  logic [WDAY_W-1:0]   acc_q;
  logic [YEAR_W-1:0]   cnt_q;
  logic [YEAR_W-1:0]   lat_year_q;
  logic [MONTH_W-1:0]  lat_month_q;
  logic [DAY_W-1:0]    lat_day_q;
  logic [DAY_W-1:0]    lat_dcnt_q;
  logic                pend_q;
  logic                ready_q;
  logic                valid_q;
  logic [YEAR_W-1:0]   year_q;
  logic [MONTH_W-1:0]  month_q;
  logic [DAY_W-1:0]    day_q;
  logic [WDAY_W-1:0]   first_q;
  logic [DAY_W-1:0]    dcnt_q;

  // Clamped set request
  logic [YEAR_W-1:0]   set_year_d;
  logic [MONTH_W-1:0]  set_month_d;
  logic [DAY_W-1:0]    set_dcnt_d;
  logic [DAY_W-1:0]    set_day_d;

  // Date one day after the current one
  logic [YEAR_W-1:0]   tick_year_d;
  logic [MONTH_W-1:0]  tick_month_d;
  logic [DAY_W-1:0]    tick_day_d;
  logic [WDAY_W-1:0]   tick_first_d;
  logic [DAY_W-1:0]    tick_dcnt_d;

  logic                set_accept;

  assign set_accept = set_if.set_valid_i && ready_q;

  always_comb begin
    set_year_d  = (set_if.set_year_i > YEAR_MAX) ? YEAR_MAX : set_if.set_year_i;
    set_month_d = (set_if.set_month_i > MONTH_MAX) ? MONTH_MAX : set_if.set_month_i;
    set_dcnt_d  = days_in_month(set_month_d, is_leap(set_year_d[1:0]));
    set_day_d   = (set_if.set_day_i >= set_dcnt_d) ? (set_dcnt_d - 5'd1) : set_if.set_day_i;
  end

  always_comb begin
    tick_year_d  = year_q;
    tick_month_d = month_q;
    tick_day_d   = day_q + 5'd1;
    tick_first_d = first_q;
    tick_dcnt_d  = dcnt_q;
    if ((day_q + 5'd1) >= dcnt_q) begin
      tick_day_d   = '0;
      tick_first_d = add_mod7(first_q, days_over_28(dcnt_q));
      if (month_q == MONTH_MAX) begin
        tick_month_d = '0;
        if (year_q == YEAR_MAX) begin
          // Century wrap restarts at the epoch rather than carrying the weekday.
          tick_year_d  = '0;
          tick_first_d = EPOCH_FIRST_DAY;
        end else begin
          tick_year_d = year_q + YEAR_W'(1);
        end
      end else begin
        tick_month_d = month_q + 4'd1;
      end
      tick_dcnt_d = days_in_month(tick_month_d, is_leap(tick_year_d[1:0]));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      acc_q       <= EPOCH_FIRST_DAY;
      cnt_q       <= '0;
      lat_year_q  <= '0;
      lat_month_q <= '0;
      lat_day_q   <= '0;
      lat_dcnt_q  <= 5'd31;
      pend_q      <= 1'b0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b1;
      year_q      <= '0;
      month_q     <= '0;
      day_q       <= '0;
      first_q     <= EPOCH_FIRST_DAY;
      dcnt_q      <= 5'd31;
    end else begin
      case (state_q)
        IDLE: begin
          if (set_accept) begin
            // A tick coinciding with the set is dropped: the entered date wins.
            lat_year_q  <= set_year_d;
            lat_month_q <= set_month_d;
            lat_day_q   <= set_day_d;
            lat_dcnt_q  <= set_dcnt_d;
            acc_q       <= EPOCH_FIRST_DAY;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
            state_q     <= YEAR;
          end else if (day_tick_i || pend_q) begin
            year_q  <= tick_year_d;
            month_q <= tick_month_d;
            day_q   <= tick_day_d;
            first_q <= tick_first_d;
            dcnt_q  <= tick_dcnt_d;
            pend_q  <= 1'b0;
          end
        end
        YEAR: begin
          if (day_tick_i) pend_q <= 1'b1;
          if (cnt_q == lat_year_q) begin
            cnt_q   <= '0;
            state_q <= (lat_month_q == '0) ? LOAD : MONTH;
          end else begin
            acc_q <= add_mod7(acc_q, is_leap(cnt_q[1:0]) ? 3'd2 : 3'd1);
            cnt_q <= cnt_q + YEAR_W'(1);
          end
        end
        MONTH: begin
          if (day_tick_i) pend_q <= 1'b1;
          acc_q <= add_mod7(acc_q,
                            days_over_28(days_in_month(cnt_q[MONTH_W-1:0],
                                                       is_leap(lat_year_q[1:0]))));
          cnt_q <= cnt_q + YEAR_W'(1);
          if (cnt_q == (YEAR_W'(lat_month_q) - YEAR_W'(1))) state_q <= LOAD;
        end
        LOAD: begin
          if (day_tick_i) pend_q <= 1'b1;
          year_q  <= lat_year_q;
          month_q <= lat_month_q;
          day_q   <= lat_day_q;
          dcnt_q  <= lat_dcnt_q;
          first_q <= acc_q;
          valid_q <= 1'b1;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign set_if.set_ready_o = ready_q;
  assign year_o             = year_q;
  assign month_o            = month_q;
  assign day_in_month_o     = day_q;
  assign month_first_day_o  = first_q;
  assign month_days_cnt_o   = dcnt_q;
  assign info_valid_o       = valid_q;

endmodule

// File: doc/cal_month_info.md
# cal_month_info

Calendar state keeper that supplies the month-view renderer with `month_first_day`, `month_days_cnt` and `day_in_month`. It tracks the current date (years 2000–2099) and advances it on a once-per-day tick from the clock core. When the user enters a date through a ready/valid set port, a sequential FSM computes the weekday of the 1st of that month. It sits between the alarm-clock timekeeping and the calendar drawing path.

## Interface
- `YEAR_W`, 7: year offset from 2000; valid values 0..99.
- `EPOCH_FIRST_DAY`, 5: weekday of 2000-01-01 (Saturday), encoded with Monday = 0.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `day_tick_i` in 1: one-cycle pulse that advances the date by one day.
- `set_valid_i` in 1: a set request is present.
- `set_ready_o` out 1: high only in IDLE.
- `set_year_i` in YEAR_W: year offset.
- `set_month_i` in 4: month, 0 = January.
- `set_day_i` in 5: day, 0-based.
- `year_o` out YEAR_W: current year offset.
- `month_o` out 4: current month.
- `day_in_month_o` out 5: current day, 0-based (0..30).
- `month_first_day_o` out 3: weekday of the 1st of the current month, Monday = 0.
- `month_days_cnt_o` out 5: number of days in the current month (28..31).
- `info_valid_o` out 1: outputs are consistent; low while a calculation is running.

## Operation
- **Reset:** all outputs return to the date 2000-01-01.
  - `year_o` = 0, `month_o` = 0, `day_in_month_o` = 0.
  - `month_first_day_o` = 5, `month_days_cnt_o` = 31.
  - `info_valid_o` = 1, `set_ready_o` = 1; FSM in IDLE; pending flag = 0.
- **Leap rule:** a year is leap iff `year[1:0] == 0`. The range contains no 2100.
- **Days per month:** 31/28(29 if leap)/31/30/31/30/31/31/30/31/30/31.
- **FSM states:** IDLE → YEAR → MONTH → LOAD → IDLE.
- **Set handshake:** a set is accepted on an edge where `set_valid_i && set_ready_o`. Inputs are clamped and latched on that edge:
  - year > 99 → 99;
  - month > 11 → 11;
  - day ≥ days of the clamped month/year → that month's days − 1.
- **YEAR state:** `acc` starts at EPOCH_FIRST_DAY. For each year y from 0 to set_year−1, one cycle adds 1 (2 if y is leap), mod 7.
- **MONTH state:** for each month m from 0 to set_month−1, one cycle adds (days(m) − 28), mod 7.
- **LOAD state:** registers all outputs from the latched values and `acc`, sets `info_valid_o` = 1, returns to IDLE.
- **Weekday arithmetic:** mod-7 on 3-bit values using compare-and-subtract; no dividers.
- **Day tick in IDLE:**
  - If `day + 1 < days_cnt`: `day` increments.
  - Otherwise:
    - `day` = 0;
    - `first_day` = (first_day + days_cnt) mod 7;
    - `month` increments; after month 11 it wraps to 0 and `year` increments;
    - `days_cnt` is recomputed for the new month.
- **Year wrap:** 2099-12-31 + tick → 2000-01-01 with `first_day` forced to EPOCH_FIRST_DAY.
- **Tick while busy** (YEAR/MONTH/LOAD): sets a one-bit pending flag. The pending tick is applied on the first IDLE cycle after LOAD, and the flag is then cleared. A second tick while the flag is already set is dropped.
- **Tick on the set-accept edge:** discarded; the user-entered date wins.
- **Reset mid-calculation:** immediate return to the reset values; any pending tick is lost.

## Timing
- A set accepted at edge T updates the outputs and raises `info_valid_o` at edge T + Y + M + 2 (Y = clamped year, M = clamped month).
- `info_valid_o` falls at edge T + 1. `set_ready_o` is low from T + 1 until the IDLE return edge.
- Worst case: Y = 99, M = 11 → 112 cycles.
- Day tick in IDLE: all outputs update on the edge that samples the tick (1-cycle latency).
- A pending tick is applied one edge after LOAD completes.
- All outputs are registered; none is combinational from an input.

## Structure
- Package `cal_date_pkg` holds:
  - the width localparams (weekday 3, day 5, month 4);
  - `EPOCH_FIRST_DAY`;
  - enum `cal_state_t` {IDLE, YEAR, MONTH, LOAD};
  - functions `is_leap(year)`, `days_in_month(month, leap)`, `add_mod7(a, b)`.
- No sub-module; the FSM, date registers and mod-7 adder fit in one module.

## Test plan
- **Reset:** assert `rst_i` mid-run → outputs read 0/0/0/5/31, `info_valid_o` = 1, `set_ready_o` = 1.
- **Set with leap February:** set year 24, month 1, day 9 → after exactly 27 cycles: `first_day` = 3, `days_cnt` = 29, `day` = 9, `info_valid_o` = 1.
- **Month rollover:** from 2024-02 with day 28, pulse the tick → month 2, day 0, `days_cnt` 31, `first_day` 4.
- **Year wrap:** set 2099-12 day 30, then tick → year 0, month 0, day 0, `first_day` 5, `days_cnt` 31.
- **Clamping:** set year 23, month 13, day 31 → month 11, day 30, `first_day` 4, latency 36 cycles.
- **Busy-window ticks and reset:** tick twice during a 2023-12 calculation → exactly one day is applied after LOAD. Separately, assert reset during MONTH → reset values, no pending tick.
